pipe_sum_row_collect: RTL and testbench

//  Final reduction stage of the dot-product adder tree, directly downstream of pipe_Sum_1.

---
 rtl/pipe_sum_row_collect.sv | 145 ++++++++++++++
 tb/tb_pipe_sum_row_collect.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sum_row_collect.sv
// pipe_sum_row_collect: final adder-tree reduction stage.
// Each accepted beat {b, a} becomes one element, (a + b) >>> 1 (floor).
// MATRIX_DIM elements are packed into a row that is offered on a valid/ready
// handshake. After MATRIX_DIM rows have been accepted, done pulses for one cycle.
module pipe_sum_row_collect #(
    parameter int WORD_LEN   = 32,
    parameter int MATRIX_DIM = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*WORD_LEN-1:0]          partial_sum_1,
    output logic [MATRIX_DIM*WORD_LEN-1:0] row_data,
    output logic                           row_valid,
    input  logic                           row_ready,
    output logic [$clog2(MATRIX_DIM)-1:0]  row_idx,
    output logic                           done
);

    localparam int IDX_W = $clog2(MATRIX_DIM);
    localparam int BUF_W = (MATRIX_DIM - 1) * WORD_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_DIM - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                           state_reg;
    logic [IDX_W-1:0]                     col_cnt_reg;
    logic [IDX_W-1:0]                     row_cnt_reg;
    logic [IDX_W-1:0]                     row_idx_reg;
    logic                                 row_valid_reg;
    logic [MATRIX_DIM*WORD_LEN-1:0]       row_data_reg;
    // Only the first MATRIX_DIM-1 columns are buffered; the last element goes
    // straight from the adder into row_data on the completing edge.
    logic [BUF_W-1:0]                     buf_reg;
    logic [BUF_W-1:0]                     buf_next;
    logic [MATRIX_DIM*WORD_LEN-1:0]       row_next;

    logic [WORD_LEN-1:0] a_val;
    logic [WORD_LEN-1:0] b_val;
    logic [WORD_LEN:0]   sum_val;
    logic [WORD_LEN-1:0] elem;
    logic                accept;
    logic                last_col;
    logic                row_take;
    logic                row_load;
    logic                final_take;

    assign a_val = partial_sum_1[WORD_LEN-1:0];
    assign b_val = partial_sum_1[2*WORD_LEN-1:WORD_LEN];

    // One extra bit holds the full signed sum, so dropping the LSB is an exact
    // floor halving and can never overflow.
    assign sum_val = {a_val[WORD_LEN-1], a_val} + {b_val[WORD_LEN-1], b_val};
    assign elem    = sum_val[WORD_LEN:1];

    assign last_col   = (col_cnt_reg == LAST_IDX);
    // Stall only when the row-completing beat would overwrite a row that is
    // still waiting; if the consumer takes it this cycle, the new row loads
    // on the same edge.
    assign in_ready   = (state_reg == S_RUN) && !(last_col && row_valid_reg && !row_ready);
    assign accept     = in_valid && in_ready;
    assign row_take   = row_valid_reg && row_ready;
    assign row_load   = accept && last_col;
    assign final_take = row_take && (row_idx_reg == LAST_IDX);

    generate
        for (genvar gi = 0; gi < MATRIX_DIM - 1; gi++) begin : g_cols
            assign buf_next[gi*WORD_LEN +: WORD_LEN] =
                (accept && col_cnt_reg == IDX_W'(gi)) ? elem : buf_reg[gi*WORD_LEN +: WORD_LEN];
            assign row_next[gi*WORD_LEN +: WORD_LEN] = buf_reg[gi*WORD_LEN +: WORD_LEN];
        end
    endgenerate
    assign row_next[(MATRIX_DIM-1)*WORD_LEN +: WORD_LEN] = elem;

    assign row_data  = row_data_reg;
    assign row_valid = row_valid_reg;
    assign row_idx   = row_idx_reg;
    assign done      = (state_reg == S_DONE);

    // Control: FSM, column/row counters and the output row handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            row_idx_reg   <= '0;
            row_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_RUN;
                        col_cnt_reg <= '0;
                        row_cnt_reg <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        col_cnt_reg <= col_cnt_reg + 1'b1;
                    end
                    if (row_load) begin
                        row_idx_reg <= row_cnt_reg;
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                    end
                    if (final_take) begin
                        state_reg     <= S_DONE;
                        row_valid_reg <= 1'b0;
                    end else if (row_load) begin
                        row_valid_reg <= 1'b1;
                    end else if (row_take) begin
                        row_valid_reg <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: column buffer and the registered output row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg      <= '0;
            row_data_reg <= '0;
        end else if (state_reg == S_IDLE) begin
            if (start) begin
                buf_reg <= '0;
            end
        end else if (state_reg == S_RUN) begin
            buf_reg <= buf_next;
            if (row_load) begin
                row_data_reg <= row_next;
            end
        end
    end

endmodule

// File: tb/tb_pipe_sum_row_collect.sv
// Testbench for pipe_sum_row_collect: arithmetic vector table, hand-written
// handshake/reset sequences, and full-matrix runs against a queue-based model.
module tb_pipe_sum_row_collect;

    localparam int WL = 32;
    localparam int MD = 8;
    localparam int RW = WL * MD;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              row_ready = 1'b0;
    logic [2*WL-1:0]   partial_sum_1 = '0;
    logic              in_ready;
    logic              row_valid;
    logic              done;
    logic [RW-1:0]     row_data;
    logic [IW-1:0]     row_idx;

    int total = 0;
    int bad   = 0;

    pipe_sum_row_collect #(.WORD_LEN(WL), .MATRIX_DIM(MD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .partial_sum_1 (partial_sum_1),
        .row_data      (row_data),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .row_idx       (row_idx),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string         name;
        logic [WL-1:0] a;
        logic [WL-1:0] b;
        logic [WL-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference element: the exact mathematical mean, rounded toward minus infinity.
    function automatic logic [WL-1:0] elem_ref(input logic [WL-1:0] a, input logic [WL-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        s = s >>> 1;
        return s[WL-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        start     = 1'b0;
        row_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_row_data", row_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one pair and hold it until the stage takes it.
    task automatic send_beat(input logic [WL-1:0] a, input logic [WL-1:0] b);
        int n;
        n = 0;
        in_valid      = 1'b1;
        partial_sum_1 = {b, a};
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got in_ready=0 want 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Whole matrix checked against a queue of expected elements.
    task automatic run_matrix(input bit rnd);
        logic [WL-1:0] q[$];
        logic [WL-1:0] a_cur;
        logic [WL-1:0] b_cur;
        logic [RW-1:0] exp_row;
        int  beats;
        int  rows;
        int  cyc;
        int  extra;
        bit  done_due;
        bit  exp_ir;
        bit  acc_beat;
        bit  acc_row;
        beats = 0; rows = 0; cyc = 0; extra = 0; done_due = 0;
        a_cur = '0; b_cur = '0;
        do_reset();
        pulse_start();
        while (cyc < 3000 && extra < 3) begin
            if (!in_valid && beats < MD * MD && (!rnd || $urandom_range(0, 3) != 0)) begin
                if (rnd) begin
                    a_cur = $urandom();
                    b_cur = $urandom();
                end else begin
                    a_cur = WL'(2 * beats);
                    b_cur = '0;
                end
                in_valid      = 1'b1;
                partial_sum_1 = {b_cur, a_cur};
            end
            row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            exp_ir = (rows < MD) && !(q.size() == 2 * MD - 1 && !row_ready);
            chk("mdl_in_ready", in_ready, exp_ir);
            chk("mdl_row_valid", row_valid, q.size() >= MD);
            chk("mdl_done", done, done_due);
            acc_beat = in_valid && in_ready;
            acc_row  = row_valid && row_ready;
            done_due = 0;
            if (acc_row && q.size() >= MD) begin
                exp_row = '0;
                for (int c = 0; c < MD; c++) exp_row[c*WL +: WL] = q[c];
                chk("mdl_row_idx", row_idx, rows);
                chk("mdl_row_data", row_data, exp_row);
                $display("row %0d idx=%0d data=%h", rows, row_idx, row_data);
                for (int c = 0; c < MD; c++) void'(q.pop_front());
                rows++;
                done_due = (rows == MD);
            end
            if (acc_beat) begin
                q.push_back(elem_ref(a_cur, b_cur));
                beats++;
            end
            if (rows == MD) extra++;
            tick();
            if (acc_beat) in_valid = 1'b0;
            cyc++;
        end
        in_valid  = 1'b0;
        row_ready = 1'b0;
        chk("mdl_rows_seen", rows, MD);
    endtask

    initial begin
        logic [RW-1:0] exp0;
        logic [RW-1:0] exp1;
        logic [WL-1:0] e;

        vecs[0] = '{"half_sum",  32'h0040_0000, 32'h0020_0000, 32'h0030_0000};
        vecs[1] = '{"neg_floor", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{"max_pos",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[3] = '{"max_neg",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vecs[4] = '{"one_zero",  32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{"m1_zero",   32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[6] = '{"mixed",     32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[7] = '{"three",     32'h0000_0003, 32'h0000_0000, 32'h0000_0001};

        // Arithmetic table: a full row of one pair per vector.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            pulse_start();
            for (int c = 0; c < MD; c++) begin
                if (c == MD - 1) begin
                    @(negedge clk);
                    chk({vecs[v].name, "_early_valid"}, row_valid, 0);
                    tick();
                end
                send_beat(vecs[v].a, vecs[v].b);
            end
            @(negedge clk);
            chk({vecs[v].name, "_valid"}, row_valid, 1);
            chk({vecs[v].name, "_idx"}, row_idx, 0);
            chk({vecs[v].name, "_data"}, row_data, {MD{vecs[v].exp}});
            $display("vector %s a=%h b=%h row=%h", vecs[v].name, vecs[v].a, vecs[v].b, row_data);
            tick();
        end

        // Backpressure: row 1 completes while row 0 is still waiting.
        do_reset();
        pulse_start();
        exp0 = '0;
        exp1 = '0;
        for (int c = 0; c < MD; c++) begin
            send_beat(WL'(4 * c), WL'(2 * c));
            exp0[c*WL +: WL] = elem_ref(WL'(4 * c), WL'(2 * c));
        end
        for (int c = 0; c < MD - 1; c++) begin
            in_valid      = 1'b1;
            partial_sum_1 = {WL'(c), WL'(100 + c)};
            exp1[c*WL +: WL] = elem_ref(WL'(100 + c), WL'(c));
            @(negedge clk);
            chk("bp_in_ready_open", in_ready, 1);
            tick();
        end
        e = elem_ref(WL'(500), WL'(-7));
        exp1[(MD-1)*WL +: WL] = e;
        partial_sum_1 = {WL'(-7), WL'(500)};
        @(negedge clk);
        chk("bp_in_ready_stall", in_ready, 0);
        chk("bp_hold_data", row_data, exp0);
        tick();
        @(negedge clk);
        chk("bp_in_ready_stall2", in_ready, 0);
        chk("bp_hold_valid", row_valid, 1);
        chk("bp_hold_idx", row_idx, 0);
        chk("bp_hold_data2", row_data, exp0);
        row_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        row_ready = 1'b0;
        @(negedge clk);
        chk("bp_row1_valid", row_valid, 1);
        chk("bp_row1_idx", row_idx, 1);
        chk("bp_row1_data", row_data, exp1);
        $display("backpressure row1=%h", row_data);
        tick();

        // Reset in the middle of a row with a row pending.
        do_reset();
        pulse_start();
        for (int c = 0; c < MD; c++) send_beat(WL'(32'h1000), '0);
        for (int c = 0; c < 3; c++) send_beat(WL'(32'h2000), '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_row_valid", row_valid, 0);
        chk("midrst_row_data", row_data, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_row_idx", row_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_start();
        exp0 = '0;
        for (int c = 0; c < MD; c++) begin
            send_beat(WL'(6 * c + 2), WL'(4));
            exp0[c*WL +: WL] = elem_ref(WL'(6 * c + 2), WL'(4));
        end
        @(negedge clk);
        chk("postrst_valid", row_valid, 1);
        chk("postrst_idx", row_idx, 0);
        chk("postrst_data", row_data, exp0);
        $display("post-reset row=%h", row_data);
        tick();

        // in_valid in IDLE and start during RUN must be ignored.
        do_reset();
        in_valid      = 1'b1;
        partial_sum_1 = {WL'(0), WL'(32'hDEAD0)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_row_valid", row_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        pulse_start();
        exp0 = '0;
        for (int c = 0; c < MD; c++) begin
            if (c == 4) pulse_start();
            send_beat(WL'(10 * c), WL'(2));
            exp0[c*WL +: WL] = elem_ref(WL'(10 * c), WL'(2));
        end
        @(negedge clk);
        chk("ign_valid", row_valid, 1);
        chk("ign_idx", row_idx, 0);
        chk("ign_data", row_data, exp0);
        $display("ignore-test row=%h", row_data);
        tick();

        // Full matrices: deterministic v=row*8+col, then randomized.
        run_matrix(1'b0);
        run_matrix(1'b1);
        run_matrix(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
